// File: rtl/arbitro_memoria_dados_if.sv
// Bus bundle between the data-memory arbiter, the nRisc core, the aux port and MemoriaDados.
// The arbiter takes the slave modport; the environment (core/aux/memory side) takes master.
interface arbitro_memoria_dados_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              core_mem_read;
  logic              core_mem_write;
  logic [ADDR_W-1:0] core_endereco;
  logic [DATA_W-1:0] core_dado_escr;
  logic [DATA_W-1:0] core_dado_lido;
  logic              core_stall;

  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_endereco;
  logic [DATA_W-1:0] aux_dado;
  logic              aux_ack;
  logic [DATA_W-1:0] aux_dado_lido;

  logic [ADDR_W-1:0] mem_endereco;
  logic [DATA_W-1:0] mem_dado_escr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_dado_lido;

  modport slave (
    input  core_mem_read, core_mem_write, core_endereco, core_dado_escr,
    input  aux_req, aux_we, aux_endereco, aux_dado, mem_dado_lido,
    output core_dado_lido, core_stall, aux_ack, aux_dado_lido,
    output mem_endereco, mem_dado_escr, mem_read, mem_write
  );

  modport master (
    output core_mem_read, core_mem_write, core_endereco, core_dado_escr,
    output aux_req, aux_we, aux_endereco, aux_dado, mem_dado_lido,
    input  core_dado_lido, core_stall, aux_ack, aux_dado_lido,
    input  mem_endereco, mem_dado_escr, mem_read, mem_write
  );
endinterface

// File: rtl/arbitro_memoria_dados.sv
// Data-memory arbiter: core has fixed priority, aux accesses fill idle memory cycles.
// Define ARB_STARVE_GUARD_EN to force an aux grant after STARVE_MAX consecutive denials.
module arbitro_memoria_dados #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  arbitro_memoria_dados_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, AUX_ISSUE, AUX_WAIT} state_e;

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [1:0]        lat_q, lat_d;
  logic              aux_ack_q, aux_ack_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
  logic              aux_we_q;
  logic [ADDR_W-1:0] aux_addr_q;
  logic [DATA_W-1:0] aux_data_q;
  logic              capture;

  logic              core_req, core_wr, core_rd;
  logic              force_aux;
  logic              mem_rd, mem_wr, stall;

  assign core_wr  = bus.core_mem_write;
  // Illegal R+W from the core resolves to a write.
  assign core_rd  = bus.core_mem_read & ~bus.core_mem_write;
  assign core_req = bus.core_mem_read | bus.core_mem_write;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d  = starve_q;
    force_aux = 1'b0;
    if (state_q == IDLE) begin
      if (!bus.aux_req) begin
        starve_d = '0;
      end else if (core_req) begin
        starve_d  = starve_q + 1'b1;
        force_aux = (starve_d == SW'(STARVE_MAX));
      end
    end else if (state_q == AUX_ISSUE) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign force_aux = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    aux_ack_d   = 1'b0;
    aux_rdata_d = aux_rdata_q;
    capture     = 1'b0;
    bus.mem_endereco  = bus.core_endereco;
    bus.mem_dado_escr = bus.core_dado_escr;
    mem_rd      = core_rd;
    mem_wr      = core_wr;
    stall       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.aux_req && (!core_req || force_aux)) begin
          state_d = AUX_ISSUE;
          capture = 1'b1;
        end
      end
      AUX_ISSUE: begin
        bus.mem_endereco  = aux_addr_q;
        bus.mem_dado_escr = aux_data_q;
        mem_wr = aux_we_q;
        mem_rd = ~aux_we_q;
        stall  = core_req;
        if (aux_we_q) begin
          aux_ack_d = 1'b1;
          state_d   = IDLE;
        end else begin
          lat_d   = LAT_INIT;
          state_d = AUX_WAIT;
        end
      end
      AUX_WAIT: begin
        bus.mem_endereco  = aux_addr_q;
        bus.mem_dado_escr = aux_data_q;
        mem_wr = 1'b0;
        mem_rd = 1'b1;
        stall  = core_req;
        if (lat_q == 2'd0) begin
          aux_rdata_d = bus.mem_dado_lido;
          aux_ack_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lat_q       <= 2'd0;
      aux_ack_q   <= 1'b0;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      aux_ack_q   <= aux_ack_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  // NOTE: captured aux request is pure datapath, only read after capture, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      aux_we_q   <= bus.aux_we;
      aux_addr_q <= bus.aux_endereco;
      aux_data_q <= bus.aux_dado;
    end
  end

  assign bus.mem_read       = mem_rd & ~rst_i;
  assign bus.mem_write      = mem_wr & ~rst_i;
  assign bus.core_stall     = stall  & ~rst_i;
  assign bus.core_dado_lido = bus.mem_dado_lido;
  assign bus.aux_ack        = aux_ack_q;
  assign bus.aux_dado_lido  = aux_rdata_q;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Directed bench for arbitro_memoria_dados with a one-cycle-latency memory model (MEM_LAT=1).
// Build with ARB_STARVE_GUARD_EN defined to exercise the forced aux grant.
module tb_arbitro_memoria_dados;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  arbitro_memoria_dados_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  arbitro_memoria_dados #(
    .DATA_W(8), .ADDR_W(8), .MEM_LAT(1), .STARVE_MAX(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] rd_q;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rd_q = 8'h00;
  end

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_endereco] <= bus.mem_dado_escr;
    if (bus.mem_read)  rd_q <= mem[bus.mem_endereco];
  end
  assign bus.mem_dado_lido = rd_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an aux access from an idle bus and measure cycles from AuxReq to AuxAck.
  task automatic aux_access(input string tag, input logic we, input logic [7:0] addr,
                            input logic [7:0] data, input int exp_lat, input logic [7:0] exp_rd);
    int  n;
    bit  got;
    n   = 0;
    got = 0;
    bus.aux_req      = 1'b1;
    bus.aux_we       = we;
    bus.aux_endereco = addr;
    bus.aux_dado     = data;
    while (!got && n < 20) begin
      tick();
      n++;
      if (bus.aux_ack === 1'b1) got = 1;
    end
    bus.aux_req = 1'b0;
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (!we) check({tag, "_rdata"}, 32'(bus.aux_dado_lido), 32'(exp_rd));
  endtask

  initial begin
    int acks;
    int stalls;

    // 1: reset held two cycles with requests pending
    rst = 1'b1;
    bus.core_mem_read  = 1'b1;
    bus.core_mem_write = 1'b0;
    bus.core_endereco  = 8'h10;
    bus.core_dado_escr = 8'h00;
    bus.aux_req        = 1'b1;
    bus.aux_we         = 1'b0;
    bus.aux_endereco   = 8'h20;
    bus.aux_dado       = 8'h00;
    #1;
    check("rst_memread_c0", 32'(bus.mem_read), 32'd0);
    check("rst_stall_c0", 32'(bus.core_stall), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      check("rst_memread", 32'(bus.mem_read), 32'd0);
      check("rst_memwrite", 32'(bus.mem_write), 32'd0);
      check("rst_stall", 32'(bus.core_stall), 32'd0);
      check("rst_auxack", 32'(bus.aux_ack), 32'd0);
    end
    check("rst_auxrdata", 32'(bus.aux_dado_lido), 32'd0);
    tick();
    rst = 1'b0;
    bus.core_mem_read = 1'b0;
    bus.aux_req       = 1'b0;
    tick();

    // 2: core write 0xA5@0x10, then read it back
    bus.core_mem_write = 1'b1;
    bus.core_endereco  = 8'h10;
    bus.core_dado_escr = 8'hA5;
    @(negedge clk);
    check("core_wr_memwrite", 32'(bus.mem_write), 32'd1);
    check("core_wr_addr", 32'(bus.mem_endereco), 32'h10);
    check("core_wr_data", 32'(bus.mem_dado_escr), 32'hA5);
    check("core_wr_stall", 32'(bus.core_stall), 32'd0);
    tick();
    bus.core_mem_write = 1'b0;
    bus.core_mem_read  = 1'b1;
    @(negedge clk);
    check("core_rd_memread", 32'(bus.mem_read), 32'd1);
    check("core_rd_stall", 32'(bus.core_stall), 32'd0);
    tick();
    bus.core_mem_read = 1'b0;
    @(negedge clk);
    check("core_rd_data", 32'(bus.core_dado_lido), 32'hA5);

    // illegal core R+W: write wins, read suppressed
    bus.core_mem_read  = 1'b1;
    bus.core_mem_write = 1'b1;
    bus.core_endereco  = 8'h11;
    bus.core_dado_escr = 8'h77;
    @(negedge clk);
    check("rw_memread", 32'(bus.mem_read), 32'd0);
    check("rw_memwrite", 32'(bus.mem_write), 32'd1);
    tick();
    bus.core_mem_write = 1'b0;
    tick();
    bus.core_mem_read = 1'b0;
    @(negedge clk);
    check("rw_readback", 32'(bus.core_dado_lido), 32'h77);
    tick();

    // 3: aux write then aux read on an idle bus
    aux_access("aux_wr", 1'b1, 8'h20, 8'h3C, 2, 8'h00);
    aux_access("aux_rd", 1'b0, 8'h20, 8'h00, 3, 8'h3C);

    // aux inputs changed after capture must be ignored
    bus.aux_req      = 1'b1;
    bus.aux_we       = 1'b1;
    bus.aux_endereco = 8'h30;
    bus.aux_dado     = 8'h5A;
    tick();
    bus.aux_endereco = 8'h31;
    bus.aux_dado     = 8'hFF;
    bus.aux_we       = 1'b0;
    @(negedge clk);
    check("cap_addr", 32'(bus.mem_endereco), 32'h30);
    check("cap_data", 32'(bus.mem_dado_escr), 32'h5A);
    check("cap_we", 32'(bus.mem_write), 32'd1);
    tick();
    check("cap_ack", 32'(bus.aux_ack), 32'd1);
    bus.aux_req = 1'b0;
    tick();
    check("cap_ack_pulse", 32'(bus.aux_ack), 32'd0);

    // 4: core read collides with an in-flight aux read
    bus.aux_req      = 1'b1;
    bus.aux_we       = 1'b0;
    bus.aux_endereco = 8'h20;
    tick();
    bus.core_mem_read = 1'b1;
    bus.core_endereco = 8'h10;
    @(negedge clk);
    check("col_issue_stall", 32'(bus.core_stall), 32'd1);
    check("col_issue_addr", 32'(bus.mem_endereco), 32'h20);
    tick();
    @(negedge clk);
    check("col_wait_stall", 32'(bus.core_stall), 32'd1);
    check("col_wait_memread", 32'(bus.mem_read), 32'd1);
    tick();
    check("col_ack", 32'(bus.aux_ack), 32'd1);
    check("col_aux_rdata", 32'(bus.aux_dado_lido), 32'h3C);
    bus.aux_req = 1'b0;
    @(negedge clk);
    check("col_ack_stall", 32'(bus.core_stall), 32'd0);
    check("col_core_addr", 32'(bus.mem_endereco), 32'h10);
    tick();
    bus.core_mem_read = 1'b0;
    @(negedge clk);
    check("col_core_data", 32'(bus.core_dado_lido), 32'hA5);
    tick();

    // 5: core requests every cycle while aux waits
    acks   = 0;
    stalls = 0;
    bus.aux_req       = 1'b1;
    bus.aux_we        = 1'b1;
    bus.aux_endereco  = 8'h40;
    bus.aux_dado      = 8'h44;
    bus.core_mem_read = 1'b1;
    bus.core_endereco = 8'h10;
`ifdef ARB_STARVE_GUARD_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.core_stall !== 1'b0) stalls++;
      if (bus.mem_endereco !== 8'h10) stalls++;
      tick();
    end
    check("guard_denied_cycles_clean", 32'(stalls), 32'd0);
    @(negedge clk);
    check("guard_issue_stall", 32'(bus.core_stall), 32'd1);
    check("guard_issue_addr", 32'(bus.mem_endereco), 32'h40);
    check("guard_issue_write", 32'(bus.mem_write), 32'd1);
    tick();
    check("guard_ack", 32'(bus.aux_ack), 32'd1);
    bus.aux_req = 1'b0;
`else
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.core_stall !== 1'b0) stalls++;
      tick();
      if (bus.aux_ack !== 1'b0) acks++;
    end
    check("starve_no_ack", 32'(acks), 32'd0);
    check("starve_no_stall", 32'(stalls), 32'd0);
    bus.aux_req = 1'b0;
`endif
    bus.core_mem_read = 1'b0;
    tick();
    tick();

    // 6: reset during AUX_WAIT abandons the access
    bus.aux_req      = 1'b1;
    bus.aux_we       = 1'b0;
    bus.aux_endereco = 8'h10;
    tick();
    tick();
    rst = 1'b1;
    bus.aux_req = 1'b0;
    @(negedge clk);
    check("rstw_memread", 32'(bus.mem_read), 32'd0);
    tick();
    rst = 1'b0;
    check("rstw_no_ack", 32'(bus.aux_ack), 32'd0);
    bus.core_mem_read = 1'b1;
    bus.core_endereco = 8'h11;
    @(negedge clk);
    check("rstw_idle_stall", 32'(bus.core_stall), 32'd0);
    check("rstw_idle_addr", 32'(bus.mem_endereco), 32'h11);
    tick();
    bus.core_mem_read = 1'b0;
    check("rstw_no_ack2", 32'(bus.aux_ack), 32'd0);
    tick();
    aux_access("post_rst_rd", 1'b0, 8'h10, 8'h00, 3, 8'hA5);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
